// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared state encoding, mode record and latency helper for
//               the parametrised SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_front = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_back  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = c_st_idle,
        FRONT = c_st_front,
        SHIFT = c_st_shift,
        BACK  = c_st_back,
        DONE  = c_st_done
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Clock cycles from the accepted wrt cycle to the done cycle.
    function automatic int unsigned spi_latency(input int unsigned data_w,
                                                input int unsigned sclk_div);
        return sclk_div * (data_w + 1) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : SCLK divider with registered SCLK and edge/half-period strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int SCLK_DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic shift_en,
    input  logic cpol,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge,
    output logic half_done
);

    localparam int c_cnt_w = $clog2(SCLK_DIV);
    localparam logic [c_cnt_w-1:0] c_lead_cnt  = c_cnt_w'(SCLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_trail_cnt = c_cnt_w'(SCLK_DIV / 2 - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sclk;

    // The shift phase starts half a period into the count, so the leading
    // edge lands on the counter wrap and the trailing edge at mid-count.
    assign lead_edge  = shift_en && (r_cnt == c_lead_cnt);
    assign trail_edge = shift_en && (r_cnt == c_trail_cnt);
    assign half_done  = en && ((r_cnt == c_lead_cnt) || (r_cnt == c_trail_cnt));
    assign sclk       = r_sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk <= 1'b0;
        end else if (lead_edge) begin
            r_sclk <= ~cpol;
        end else if (trail_edge || !shift_en) begin
            r_sclk <= cpol;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_gen
// Description : Parametrised SPI master, all four CPOL/CPHA modes, wrt/done
//               handshake with busy and illegal slave-select rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SCLK_DIV = 32,
    parameter int NUM_SS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [2:0]        ss_sel,
    input  logic [1:0]        mode,
    output logic [NUM_SS-1:0] SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data
);

    localparam int c_bit_w = $clog2(DATA_W + 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_W - 1);
    localparam logic [3:0]         c_num_ss   = 4'(NUM_SS);

    logic [2:0]         r_state;
    spi_mode_t          r_mode;
    logic [DATA_W-1:0]  r_shift;
    logic [c_bit_w-1:0] r_bits;
    logic               r_mosi;
    logic [NUM_SS-1:0]  r_ss_n;
    logic [DATA_W-1:0]  r_rd;
    logic               r_err;

    logic w_can_start;
    logic w_ss_ok;
    logic w_start;
    logic w_reject;
    logic w_active;
    logic w_shift;
    logic w_cpol;
    logic w_lead;
    logic w_trail;
    logic w_half_done;

    // DONE behaves like IDLE for new requests so back-to-back words only
    // lose the single SS_n-high cycle.
    assign w_can_start = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_ss_ok     = ({1'b0, ss_sel} < c_num_ss);
    assign w_start     = w_can_start && wrt && w_ss_ok;
    assign w_reject    = w_can_start && wrt && !w_ss_ok;
    assign w_active    = (r_state == c_st_front) || (r_state == c_st_shift) ||
                         (r_state == c_st_back);
    assign w_shift     = (r_state == c_st_shift);
    assign w_cpol      = w_can_start ? mode[1] : r_mode.cpol;

    spi_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (w_active),
        .shift_en   (w_shift),
        .cpol       (w_cpol),
        .sclk       (SCLK),
        .lead_edge  (w_lead),
        .trail_edge (w_trail),
        .half_done  (w_half_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_mode  <= '0;
            r_shift <= '0;
            r_bits  <= '0;
            r_mosi  <= 1'b0;
            r_ss_n  <= '1;
            r_rd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_reject;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_start) begin
                        r_state <= c_st_front;
                        r_mode  <= spi_mode_t'(mode);
                        r_shift <= cmd;
                        r_bits  <= '0;
                        r_ss_n  <= ~(NUM_SS'(1) << ss_sel);
                        if (!mode[0]) begin
                            r_mosi <= cmd[DATA_W-1];
                        end
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_front: begin
                    if (w_half_done) begin
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    // One register serves both directions: MISO enters at the
                    // LSB as the outgoing MSB leaves.
                    if (w_lead) begin
                        if (r_mode.cpha) begin
                            r_mosi <= r_shift[DATA_W-1];
                        end else begin
                            r_shift <= {r_shift[DATA_W-2:0], MISO};
                        end
                    end
                    if (w_trail) begin
                        r_bits <= r_bits + c_bit_w'(1);
                        if (r_mode.cpha) begin
                            r_shift <= {r_shift[DATA_W-2:0], MISO};
                        end else begin
                            r_mosi <= r_shift[DATA_W-1];
                        end
                        if (r_bits == c_last_bit) begin
                            r_state <= c_st_back;
                        end
                    end
                end
                c_st_back: begin
                    if (w_half_done) begin
                        r_state <= c_st_done;
                        r_ss_n  <= '1;
                        r_rd    <= r_shift;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign SS_n    = r_ss_n;
    assign MOSI    = r_mosi;
    assign busy    = w_active;
    assign done    = (r_state == c_st_done);
    assign err     = r_err;
    assign rd_data = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_gen
// Description : Self-checking bench: default-size master against an ADC model
//               and in loopback, plus a small 8-bit / 4-slave instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Default instance: DATA_W=16, SCLK_DIV=32, NUM_SS=1
    logic        d_wrt = 1'b0;
    logic [15:0] d_cmd = '0;
    logic [2:0]  d_ss = '0;
    logic [1:0]  d_mode = '0;
    logic [0:0]  d_ss_n;
    logic        d_sclk, d_mosi, d_miso, d_busy, d_done, d_err;
    logic [15:0] d_rd;
    logic        d_loop = 1'b0;

    // Small instance: DATA_W=8, SCLK_DIV=4, NUM_SS=4, MOSI looped to MISO
    logic        s_wrt = 1'b0;
    logic [7:0]  s_cmd = '0;
    logic [2:0]  s_ss = '0;
    logic [1:0]  s_mode = '0;
    logic [3:0]  s_ss_n;
    logic        s_sclk, s_mosi, s_miso, s_busy, s_done, s_err;
    logic [7:0]  s_rd;
    logic [7:0]  s_last_rd = '0;

    spi_master_gen u_def (
        .clk (clk), .rst (rst), .wrt (d_wrt), .cmd (d_cmd), .ss_sel (d_ss),
        .mode (d_mode), .SS_n (d_ss_n), .SCLK (d_sclk), .MOSI (d_mosi),
        .MISO (d_miso), .busy (d_busy), .done (d_done), .err (d_err),
        .rd_data (d_rd)
    );

    spi_master_gen #(.DATA_W (8), .SCLK_DIV (4), .NUM_SS (4)) u_small (
        .clk (clk), .rst (rst), .wrt (s_wrt), .cmd (s_cmd), .ss_sel (s_ss),
        .mode (s_mode), .SS_n (s_ss_n), .SCLK (s_sclk), .MOSI (s_mosi),
        .MISO (s_miso), .busy (s_busy), .done (s_done), .err (s_err),
        .rd_data (s_rd)
    );

    assign s_miso = s_mosi;

    // ADC128S-style slave: returns the channel addressed in the previous
    // frame, base value 0xC00 dropping by 0x10 every second conversion.
    logic        adc_on = 1'b0;
    logic        adc_dout = 1'b0;
    logic [15:0] adc_sh = '0;
    logic [15:0] adc_din = '0;
    logic [2:0]  adc_ch = '0;
    int          adc_frame = 0;

    assign d_miso = d_loop ? d_mosi : adc_dout;

    always @(negedge d_ss_n[0]) if (adc_on) begin
        adc_sh   = 16'h0C00 - 16'((adc_frame / 2) * 16) + {13'd0, adc_ch};
        adc_dout = adc_sh[15];
    end
    always @(negedge d_sclk) if (adc_on && !d_ss_n[0]) begin
        adc_sh   = adc_sh << 1;
        adc_dout = adc_sh[15];
    end
    always @(posedge d_sclk) if (adc_on && !d_ss_n[0]) adc_din = {adc_din[14:0], d_mosi};
    always @(posedge d_ss_n[0]) if (adc_on) begin
        adc_ch    = adc_din[13:11];
        adc_frame = adc_frame + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One default-instance transfer; optionally re-pulses wrt with 0xFFFF at
    // cycle 'poke'. lat is the done cycle counted from the wrt cycle, -1 on timeout.
    task automatic def_xfer(input logic [15:0] c, input int poke, output int lat);
        @(negedge clk);
        d_cmd = c;
        d_wrt = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(negedge clk);
            d_wrt = 1'b0;
            if (cyc == 1) begin
                chk("def_ss_low", {31'd0, d_ss_n}, 32'd0);
                chk("def_busy", {31'd0, d_busy}, 32'd1);
            end
            if (cyc == poke) begin
                d_wrt = 1'b1;
                d_cmd = 16'hFFFF;
            end
            if (d_done) begin
                lat = cyc;
                break;
            end
        end
        d_wrt = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [2:0] ss;
        logic [7:0] cmd;
        logic [3:0] ssn;
        logic       bad_ss;
        logic [7:0] rd;
    } svec_t;

    task automatic run_small(input svec_t v, input int idx);
        int   lat, periods, bad, nd, ne;
        logic prev;
        @(negedge clk);
        s_mode = v.mode;
        s_ss   = v.ss;
        s_cmd  = v.cmd;
        @(negedge clk);
        chk($sformatf("s%0d_idle_sclk", idx), {31'd0, s_sclk}, {31'd0, v.mode[1]});
        s_wrt = 1'b1;
        @(posedge clk);
        if (v.bad_ss) begin
            @(negedge clk);
            s_wrt = 1'b0;
            chk($sformatf("s%0d_err_pulse", idx), {31'd0, s_err}, 32'd1);
            chk($sformatf("s%0d_err_ssn", idx), {28'd0, s_ss_n}, 32'hF);
            chk($sformatf("s%0d_err_busy", idx), {31'd0, s_busy}, 32'd0);
            nd = 0; ne = 0; bad = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                nd += int'(s_done);
                ne += int'(s_err);
                if (s_ss_n != 4'hF || s_busy) bad++;
            end
            chk($sformatf("s%0d_err_once", idx), ne, 0);
            chk($sformatf("s%0d_err_nodone", idx), nd, 0);
            chk($sformatf("s%0d_err_idle", idx), bad, 0);
            chk($sformatf("s%0d_err_rd", idx), {24'd0, s_rd}, {24'd0, s_last_rd});
        end else begin
            lat = -1; periods = 0; bad = 0; prev = v.mode[1];
            for (int cyc = 1; cyc <= 80; cyc++) begin
                @(negedge clk);
                s_wrt = 1'b0;
                if (cyc == 3) begin
                    s_cmd = ~v.cmd; s_mode = ~v.mode; s_ss = 3'd6;
                end
                if (cyc == 12) begin
                    s_cmd = v.cmd; s_mode = v.mode; s_ss = v.ss;
                end
                if (s_ss_n != 4'hF) begin
                    if (s_ss_n != v.ssn) bad++;
                    if (s_sclk != prev && s_sclk != v.mode[1]) periods++;
                end
                prev = s_sclk;
                if (s_done) begin
                    lat = cyc;
                    break;
                end
            end
            chk($sformatf("s%0d_latency", idx), lat, 37);
            chk($sformatf("s%0d_rd_data", idx), {24'd0, s_rd}, {24'd0, v.rd});
            chk($sformatf("s%0d_periods", idx), periods, 8);
            chk($sformatf("s%0d_ssn_pattern", idx), bad, 0);
            @(negedge clk);
            chk($sformatf("s%0d_sclk_after", idx), {31'd0, s_sclk}, {31'd0, v.mode[1]});
            chk($sformatf("s%0d_busy_after", idx), {31'd0, s_busy}, 32'd0);
            s_last_rd = v.rd;
        end
    endtask

    logic [15:0] adc_cmd [4] = '{16'h2800, 16'h2800, 16'h2000, 16'h2000};
    logic [15:0] adc_exp [4] = '{16'h0C00, 16'h0C05, 16'h0BF5, 16'h0BF4};

    initial begin
        svec_t tbl [9];
        int lat, t1, t2, hi_cnt, nd;
        logic [15:0] rd1, rd2;

        tbl[0] = '{2'd0, 3'd0, 8'hA5, 4'hE, 1'b0, 8'hA5};
        tbl[1] = '{2'd1, 3'd0, 8'hA5, 4'hE, 1'b0, 8'hA5};
        tbl[2] = '{2'd2, 3'd0, 8'hA5, 4'hE, 1'b0, 8'hA5};
        tbl[3] = '{2'd3, 3'd0, 8'hA5, 4'hE, 1'b0, 8'hA5};
        tbl[4] = '{2'd0, 3'd2, 8'h3C, 4'hB, 1'b0, 8'h3C};
        tbl[5] = '{2'd3, 3'd3, 8'h81, 4'h7, 1'b0, 8'h81};
        tbl[6] = '{2'd1, 3'd5, 8'h00, 4'hF, 1'b1, 8'h00};
        tbl[7] = '{2'd0, 3'd4, 8'h00, 4'hF, 1'b1, 8'h00};
        tbl[8] = '{2'd2, 3'd1, 8'h5E, 4'hD, 1'b0, 8'h5E};

        repeat (3) @(negedge clk);
        chk("rst_ss_n", {31'd0, d_ss_n}, 32'd1);
        chk("rst_sclk", {31'd0, d_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, d_mosi}, 32'd0);
        chk("rst_busy", {31'd0, d_busy}, 32'd0);
        chk("rst_done", {31'd0, d_done}, 32'd0);
        chk("rst_err", {31'd0, d_err}, 32'd0);
        chk("rst_rd", {16'd0, d_rd}, 32'd0);
        chk("rst_s_ss_n", {28'd0, s_ss_n}, 32'hF);
        chk("rst_s_rd", {24'd0, s_rd}, 32'd0);
        rst = 1'b0;

        // ADC conversions, mode 0
        adc_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            def_xfer(adc_cmd[i], -1, lat);
            chk($sformatf("adc%0d_latency", i), lat, 545);
            chk($sformatf("adc%0d_rd", i), {16'd0, d_rd}, {16'd0, adc_exp[i]});
        end
        adc_on = 1'b0;
        d_loop = 1'b1;

        for (int i = 0; i < 9; i++) run_small(tbl[i], i);

        // wrt while busy is ignored
        def_xfer(16'h1234, 100, lat);
        chk("busy_wrt_latency", lat, 545);
        chk("busy_wrt_rd", {16'd0, d_rd}, 32'h1234);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            nd += int'(d_done);
        end
        chk("busy_wrt_one_done", nd, 0);

        // Back-to-back with wrt held across DONE
        @(negedge clk);
        d_cmd = 16'h5A5A;
        d_wrt = 1'b1;
        @(posedge clk);
        t1 = -1; t2 = -1; hi_cnt = 0; rd1 = '0; rd2 = '0;
        for (int cyc = 1; cyc <= 1200; cyc++) begin
            @(negedge clk);
            if (cyc == 2) d_cmd = 16'hC3C3;
            if (d_done) begin
                if (t1 < 0) begin
                    t1 = cyc; rd1 = d_rd;
                end else begin
                    t2 = cyc; rd2 = d_rd;
                    break;
                end
            end
            if (t1 >= 0 && d_ss_n[0]) hi_cnt++;
        end
        d_wrt = 1'b0;
        chk("b2b_first_done", t1, 545);
        chk("b2b_second_done", t2, 1090);
        chk("b2b_rd1", {16'd0, rd1}, 32'h5A5A);
        chk("b2b_rd2", {16'd0, rd2}, 32'hC3C3);
        chk("b2b_ss_high_cycles", hi_cnt, 1);
        @(negedge clk);
        chk("b2b_idle_after", {31'd0, d_busy}, 32'd0);

        // Reset in the middle of a transaction
        @(negedge clk);
        d_cmd = 16'h1357;
        d_wrt = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            d_wrt = 1'b0;
        end
        chk("pre_rst_sclk", {31'd0, d_sclk}, 32'd1);
        chk("pre_rst_busy", {31'd0, d_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ss_n", {31'd0, d_ss_n}, 32'd1);
        chk("mid_rst_sclk", {31'd0, d_sclk}, 32'd0);
        chk("mid_rst_busy", {31'd0, d_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, d_done}, 32'd0);
        chk("mid_rst_rd", {16'd0, d_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            nd += int'(d_done);
        end
        chk("mid_rst_no_done", nd, 0);
        def_xfer(16'h2468, -1, lat);
        chk("post_rst_latency", lat, 545);
        chk("post_rst_rd", {16'd0, d_rd}, 32'h2468);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
